// File: rtl/cpu_pkg.sv
// Shared types and widths for the CPU front end.
`timescale 1ns/1ps
package cpu_pkg;

    localparam int INSTR_W = 32;
    localparam int PC_W    = 32;
    localparam int IFID_W  = 64;

    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;

    // IDLE: nothing outstanding
    // WAIT: one request outstanding, response kept
    // DROP: one request outstanding, response discarded
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO between instruction memory and the IF/ID register.
// Registered head, no write-through bypass; an empty FIFO presents all zeros.
`timescale 1ns/1ps
module fetch_fifo
    import cpu_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              push,
    input  logic              pop,
    input  logic              clear,
    input  logic [IFID_W-1:0] wdata,
    output logic              full,
    output logic [CNT_W-1:0]  count,
    output logic [IFID_W-1:0] head
);

    logic [IFID_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic              empty;
    logic              do_push;
    logic              do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign do_pop  = pop && !empty;
    // A push into a full FIFO is only legal when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);
    assign head    = empty ? {{PC_W{1'b0}}, NOP_INSTR} : mem[rd_ptr];

    // Pointer and occupancy bookkeeping; clear wins over push/pop.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: the head is masked while the FIFO is empty.
    always_ff @(posedge clk_i) begin
        if (do_push && !clear) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: PC, single-outstanding imem requests, prefetch
// buffering and the producer side of the IF/ID register.
`timescale 1ns/1ps
module if_fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC = 32'h0000_0000,
    parameter int              DEPTH    = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              stall_i,
    input  logic              redirect_i,
    input  logic [PC_W-1:0]   redirect_pc_i,
    output logic              imem_req_o,
    output logic [PC_W-1:0]   imem_addr_o,
    input  logic              imem_ack_i,
    input  logic [INSTR_W-1:0] imem_rdata_i,
    output logic [IFID_W-1:0] ifid_data_o,
    output logic              ifid_valid_o
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    fetch_state_e     state;
    fetch_state_e     state_next;
    logic [PC_W-1:0]  pc;
    logic [PC_W-1:0]  pc_next;
    logic [PC_W-1:0]  pc_plus4;
    logic [PC_W-1:0]  fetch_pc;
    logic [CNT_W-1:0] fifo_count;
    logic             fifo_full;
    logic             ack_wait;
    logic             push;
    logic             pop;
    logic             room;
    logic             issue;
    logic             unused_pc_bits;

    assign unused_pc_bits = ^redirect_pc_i[1:0];

    assign pc_plus4     = pc + 32'd4;
    assign ack_wait     = (state == WAIT) && imem_ack_i;
    assign push         = ack_wait && !redirect_i;
    assign pop          = ifid_valid_o && !stall_i && !redirect_i;
    assign ifid_valid_o = (fifo_count != '0);

    // Space test against the occupancy after this cycle's push/pop.
    // A push only ever happens with at least one free slot, so it cannot overflow.
    always_comb begin
        if (pop)       room = 1'b1;
        else if (push) room = (fifo_count < CNT_W'(DEPTH - 1));
        else           room = !fifo_full;
    end

    // Issue decision and fetch address; gated by reset so the bus is quiet while held.
    always_comb begin
        fetch_pc    = ack_wait ? pc_plus4 : pc;
        issue       = rst_i && !redirect_i && room && ((state == IDLE) || ack_wait);
        imem_req_o  = issue;
        imem_addr_o = issue ? fetch_pc : '0;
    end

    // Next-state and PC update; redirect takes priority over everything else.
    always_comb begin
        state_next = state;
        pc_next    = pc;
        if (redirect_i) begin
            pc_next    = {redirect_pc_i[PC_W-1:2], 2'b00};
            state_next = ((state != IDLE) && !imem_ack_i) ? DROP : IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (issue) state_next = WAIT;
                end
                WAIT: begin
                    if (imem_ack_i) begin
                        pc_next    = pc_plus4;
                        state_next = issue ? WAIT : IDLE;
                    end
                end
                DROP: begin
                    if (imem_ack_i) state_next = IDLE;
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // State and PC registers.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state <= IDLE;
            pc    <= RESET_PC;
        end else begin
            state <= state_next;
            pc    <= pc_next;
        end
    end

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .push  (push),
        .pop   (pop),
        .clear (redirect_i),
        .wdata ({pc_plus4, imem_rdata_i}),
        .full  (fifo_full),
        .count (fifo_count),
        .head  (ifid_data_o)
    );

endmodule
